// File: rtl/npc_bp_if.sv
// Next-PC unit bundle: fetch-side prediction outputs and EX resolution inputs.
// master = pipeline side, slave = npc_bp side.
interface npc_bp_if #(
    parameter int unsigned XLEN = 32
);
    logic            stall;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic [1:0]      ex_op;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_offset;
    logic            ex_br;
    logic            ex_osel;
    logic            ex_pred_taken;
    logic [XLEN-1:0] ex_pred_target;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output stall, ex_valid, ex_op, ex_pc, ex_offset, ex_br, ex_osel,
        output ex_pred_taken, ex_pred_target,
        input  pc, pc4, pred_taken, pred_target, redirect, redirect_pc
    );

    modport slave (
        input  stall, ex_valid, ex_op, ex_pc, ex_offset, ex_br, ex_osel,
        input  ex_pred_taken, ex_pred_target,
        output pc, pc4, pred_taken, pred_target, redirect, redirect_pc
    );
endinterface

// File: rtl/npc_bp.sv
// Fetch PC register with BTB/2-bit-counter prediction and EX-stage redirect.
// Define NPC_BTB_EN to build the BTB; otherwise static not-taken prediction.
module npc_bp #(
    parameter int unsigned    XLEN      = 32,
    parameter int unsigned    BTB_DEPTH = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic    clk,
    input logic    rst,
    npc_bp_if.slave bus
);
    localparam logic [1:0]      OP_BR  = 2'b01;
    localparam logic [1:0]      OP_JMP = 2'b10;
    localparam logic [XLEN-1:0] FOUR   = XLEN'(4);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] ex_pc4;
    logic [XLEN-1:0] act_tgt;
    logic            is_br;
    logic            is_jmp;
    logic            act_taken;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            redirect;

    assign pc4    = pc_q + FOUR;
    assign ex_pc4 = bus.ex_pc + FOUR;
    assign is_br  = (bus.ex_op == OP_BR);
    assign is_jmp = (bus.ex_op == OP_JMP);

    // Op 11 falls through as sequential since neither decode matches.
    assign act_taken = (is_br && bus.ex_br) || is_jmp;
    assign act_tgt   = (is_jmp && bus.ex_osel) ? bus.ex_offset
                                               : bus.ex_pc + bus.ex_offset;

    assign redirect = bus.ex_valid &&
                      ((act_taken != bus.ex_pred_taken) ||
                       (act_taken && (act_tgt != bus.ex_pred_target)));

`ifdef NPC_BTB_EN
    localparam int unsigned IDX  = $clog2(BTB_DEPTH);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAGW-1:0]      tag_q [BTB_DEPTH];
    logic [XLEN-1:0]      tgt_q [BTB_DEPTH];
    logic [1:0]           cnt_q [BTB_DEPTH];

    logic [IDX-1:0]  l_idx;
    logic [TAGW-1:0] l_tag;
    logic            l_hit;
    logic [IDX-1:0]  u_idx;
    logic [TAGW-1:0] u_tag;
    logic            u_hit;
    logic            upd;

    assign l_idx = pc_q[IDX+1:2];
    assign l_tag = pc_q[XLEN-1:IDX+2];
    assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

    assign pred_taken  = l_hit && cnt_q[l_idx][1];
    assign pred_target = pred_taken ? tgt_q[l_idx] : pc4;

    assign u_idx = bus.ex_pc[IDX+1:2];
    assign u_tag = bus.ex_pc[XLEN-1:IDX+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign upd   = bus.ex_valid && (is_br || is_jmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
                cnt_q[i] <= 2'b01;
            end
        end else if (upd) begin
            if (u_hit) begin
                if (is_jmp) begin
                    cnt_q[u_idx] <= 2'b11;
                end else if (act_taken && cnt_q[u_idx] != 2'b11) begin
                    cnt_q[u_idx] <= cnt_q[u_idx] + 2'd1;
                end else if (!act_taken && cnt_q[u_idx] != 2'b00) begin
                    cnt_q[u_idx] <= cnt_q[u_idx] - 2'd1;
                end
            end else if (act_taken) begin
                valid_q[u_idx] <= 1'b1;
                cnt_q[u_idx]   <= is_jmp ? 2'b11 : 2'b10;
            end
        end
    end

    // Tag and target only matter once valid is set, so they need no reset.
    always_ff @(posedge clk) begin
        if (!rst && upd && act_taken) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= act_tgt;
        end
    end
`else
    assign pred_taken  = 1'b0;
    assign pred_target = pc4;
`endif

    always_comb begin
        pc_d = pred_target;
        if (redirect) begin
            pc_d = bus.redirect_pc;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc4         = pc4;
    assign bus.pred_taken  = pred_taken;
    assign bus.pred_target = pred_target;
    assign bus.redirect    = redirect;
    assign bus.redirect_pc = act_taken ? act_tgt : ex_pc4;
endmodule

// File: tb/tb_npc_bp.sv
// Directed bench for npc_bp; prediction expectations follow NPC_BTB_EN.
// Inputs change 1ns after the rising edge, outputs are checked 1ns later.
module tb_npc_bp;
`ifdef NPC_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;

    npc_bp_if #(.XLEN(32)) bus ();

    npc_bp #(
        .XLEN     (32),
        .BTB_DEPTH(64),
        .RESET_PC (32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.stall          = 1'b0;
        bus.ex_valid       = 1'b0;
        bus.ex_op          = 2'b00;
        bus.ex_pc          = '0;
        bus.ex_offset      = '0;
        bus.ex_br          = 1'b0;
        bus.ex_osel        = 1'b0;
        bus.ex_pred_taken  = 1'b0;
        bus.ex_pred_target = '0;
    endtask

    task automatic drive_ex(input logic [1:0] op, input logic [31:0] epc,
                            input logic [31:0] off, input logic br,
                            input logic osel, input logic pt,
                            input logic [31:0] ptgt);
        bus.ex_valid       = 1'b1;
        bus.ex_op          = op;
        bus.ex_pc          = epc;
        bus.ex_offset      = off;
        bus.ex_br          = br;
        bus.ex_osel        = osel;
        bus.ex_pred_taken  = pt;
        bus.ex_pred_target = ptgt;
    endtask

    // Mispredicted absolute jump from 0x800 to steer the fetch PC.
    task automatic goto(input logic [31:0] addr);
        drive_ex(2'b10, 32'h800, addr, 1'b0, 1'b1, 1'b0, 32'h0);
        tick;
        idle;
        #1;
    endtask

    task automatic test_reset;
        idle;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        total++;
        if (bus.pc !== 32'h0) begin
            bad++; $display("FAIL reset_pc got=%h want=%h", bus.pc, 32'h0);
        end
        total++;
        if (bus.pc4 !== 32'h4) begin
            bad++; $display("FAIL reset_pc4 got=%h want=%h", bus.pc4, 32'h4);
        end
        total++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h4) begin
            bad++;
            $display("FAIL reset_pred got=%b/%h want=0/%h",
                     bus.pred_taken, bus.pred_target, 32'h4);
        end
        total++;
        if (bus.redirect !== 1'b0) begin
            bad++; $display("FAIL reset_redirect got=%b want=0", bus.redirect);
        end
    endtask

    task automatic test_sequential;
        for (int i = 1; i <= 3; i++) begin
            tick;
            total++;
            if (bus.pc !== 32'(4 * i) || bus.redirect !== 1'b0) begin
                bad++;
                $display("FAIL seq_pc got=%h/%b want=%h/0",
                         bus.pc, bus.redirect, 32'(4 * i));
            end
        end
    endtask

    task automatic test_taken_branch;
        drive_ex(2'b01, 32'h10, 32'h20, 1'b1, 1'b0, 1'b0, 32'h14);
        #1;
        total++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h30) begin
            bad++;
            $display("FAIL br_redirect got=%b/%h want=1/%h",
                     bus.redirect, bus.redirect_pc, 32'h30);
        end
        tick;
        idle;
        #1;
        total++;
        if (bus.pc !== 32'h30) begin
            bad++; $display("FAIL br_pc got=%h want=%h", bus.pc, 32'h30);
        end
        goto(32'h10);
        total++;
        if (bus.pc !== 32'h10 || bus.pred_taken !== BTB ||
            bus.pred_target !== (BTB ? 32'h30 : 32'h14)) begin
            bad++;
            $display("FAIL br_predict got=%h/%b/%h want=%h/%b/%h",
                     bus.pc, bus.pred_taken, bus.pred_target,
                     32'h10, BTB, BTB ? 32'h30 : 32'h14);
        end
    endtask

    task automatic test_loop_exit;
        drive_ex(2'b01, 32'h10, 32'h20, 1'b1, 1'b0, BTB,
                 BTB ? 32'h30 : 32'h14);
        tick;
        drive_ex(2'b01, 32'h10, 32'h20, 1'b0, 1'b0, 1'b1, 32'h30);
        #1;
        total++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h14) begin
            bad++;
            $display("FAIL exit_redirect got=%b/%h want=1/%h",
                     bus.redirect, bus.redirect_pc, 32'h14);
        end
        tick;
        idle;
        #1;
        total++;
        if (bus.pc !== 32'h14) begin
            bad++; $display("FAIL exit_pc got=%h want=%h", bus.pc, 32'h14);
        end
        goto(32'h10);
        total++;
        if (bus.pred_taken !== BTB ||
            bus.pred_target !== (BTB ? 32'h30 : 32'h14)) begin
            bad++;
            $display("FAIL exit_still_taken got=%b/%h want=%b/%h",
                     bus.pred_taken, bus.pred_target,
                     BTB, BTB ? 32'h30 : 32'h14);
        end
        drive_ex(2'b01, 32'h10, 32'h20, 1'b0, 1'b0, BTB,
                 BTB ? 32'h30 : 32'h14);
        tick;
        goto(32'h10);
        total++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h14) begin
            bad++;
            $display("FAIL exit_weak_nt got=%b/%h want=0/%h",
                     bus.pred_taken, bus.pred_target, 32'h14);
        end
    endtask

    task automatic test_resolution;
        drive_ex(2'b10, 32'h200, 32'h400, 1'b0, 1'b1, 1'b1, 32'h300);
        #1;
        total++;
        if (bus.redirect !== 1'b1 || bus.redirect_pc !== 32'h400) begin
            bad++;
            $display("FAIL ind_mismatch got=%b/%h want=1/%h",
                     bus.redirect, bus.redirect_pc, 32'h400);
        end
        bus.ex_pred_target = 32'h400;
        #1;
        total++;
        if (bus.redirect !== 1'b0) begin
            bad++; $display("FAIL ind_match got=%b want=0", bus.redirect);
        end
        drive_ex(2'b11, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        total++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h44) begin
            bad++;
            $display("FAIL op_reserved got=%b/%h want=0/%h",
                     bus.redirect, bus.redirect_pc, 32'h44);
        end
        drive_ex(2'b01, 32'h10, 32'h20, 1'b1, 1'b0, 1'b0, 32'h0);
        bus.ex_valid = 1'b0;
        #1;
        total++;
        if (bus.redirect !== 1'b0) begin
            bad++; $display("FAIL ex_invalid got=%b want=0", bus.redirect);
        end
        drive_ex(2'b01, 32'hFFFF_FFFC, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        total++;
        if (bus.redirect_pc !== 32'h4) begin
            bad++; $display("FAIL wrap got=%h want=%h", bus.redirect_pc, 32'h4);
        end
        drive_ex(2'b10, 32'h100, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1, 32'hF0);
        #1;
        total++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'hF0) begin
            bad++;
            $display("FAIL jal_rel got=%b/%h want=0/%h",
                     bus.redirect, bus.redirect_pc, 32'hF0);
        end
        drive_ex(2'b01, 32'h100, 32'h40, 1'b1, 1'b1, 1'b1, 32'h140);
        #1;
        total++;
        if (bus.redirect !== 1'b0 || bus.redirect_pc !== 32'h140) begin
            bad++;
            $display("FAIL br_osel got=%b/%h want=0/%h",
                     bus.redirect, bus.redirect_pc, 32'h140);
        end
        idle;
        #1;
    endtask

    task automatic test_stall;
        drive_ex(2'b10, 32'h200, 32'h400, 1'b0, 1'b1, 1'b0, 32'h0);
        bus.stall = 1'b1;
        tick;
        idle;
        bus.stall = 1'b1;
        #1;
        total++;
        if (bus.pc !== 32'h400) begin
            bad++; $display("FAIL stall_redir got=%h want=%h", bus.pc, 32'h400);
        end
        for (int i = 0; i < 2; i++) begin
            tick;
            total++;
            if (bus.pc !== 32'h400) begin
                bad++; $display("FAIL stall_hold got=%h want=%h", bus.pc, 32'h400);
            end
        end
        bus.stall = 1'b0;
        tick;
        total++;
        if (bus.pc !== 32'h404) begin
            bad++; $display("FAIL stall_release got=%h want=%h", bus.pc, 32'h404);
        end
    endtask

    task automatic test_alias;
        drive_ex(2'b01, 32'h10, 32'h20, 1'b1, 1'b0, 1'b0, 32'h14);
        tick;
        goto(32'h10);
        total++;
        if (bus.pred_taken !== BTB) begin
            bad++; $display("FAIL alias_pre got=%b want=%b", bus.pred_taken, BTB);
        end
        drive_ex(2'b01, 32'h110, 32'h20, 1'b1, 1'b0, 1'b0, 32'h114);
        tick;
        goto(32'h10);
        total++;
        if (bus.pred_taken !== 1'b0 || bus.pred_target !== 32'h14) begin
            bad++;
            $display("FAIL alias_evict got=%b/%h want=0/%h",
                     bus.pred_taken, bus.pred_target, 32'h14);
        end
        goto(32'h110);
        total++;
        if (bus.pred_taken !== BTB ||
            bus.pred_target !== (BTB ? 32'h130 : 32'h114)) begin
            bad++;
            $display("FAIL alias_new got=%b/%h want=%b/%h",
                     bus.pred_taken, bus.pred_target,
                     BTB, BTB ? 32'h130 : 32'h114);
        end
    endtask

    task automatic test_reset_mid;
        drive_ex(2'b01, 32'h10, 32'h20, 1'b1, 1'b0, 1'b0, 32'h14);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        idle;
        #1;
        total++;
        if (bus.pc !== 32'h0 || bus.redirect !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid got=%h/%b want=0/0", bus.pc, bus.redirect);
        end
        goto(32'h110);
        total++;
        if (bus.pred_taken !== 1'b0) begin
            bad++; $display("FAIL rst_btb_clear got=%b want=0", bus.pred_taken);
        end
        goto(32'h10);
        total++;
        if (bus.pred_taken !== 1'b0) begin
            bad++; $display("FAIL rst_no_alloc got=%b want=0", bus.pred_taken);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle;
        test_reset;
        test_sequential;
        test_taken_branch;
        test_loop_exit;
        test_resolution;
        test_stall;
        test_alias;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
